// File: rtl/or1200_vlx_rd.sv
// OR1200 VLX variable-length bit reader: fetches bytes, removes JPEG 0xFF00
// stuffing, and serves 0..16-bit get-bit requests from an MSB-aligned buffer.
module or1200_vlx_rd (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        get_bit_op_i,
    input  logic [4:0]  num_bits_to_read_i,
    output logic [31:0] bits_o,
    output logic        stall_cpu_o,
    input  logic        spr_cs,
    input  logic        spr_write,
    input  logic [1:0]  spr_addr,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o,
    output logic [31:0] vlx_addr_o,
    output logic        load_byte_o,
    input  logic        ack_i,
    input  logic [7:0]  dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FF_REQ = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] bitbuf_q, bitbuf_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        en_q, en_d;
    logic        marker_q, marker_d;

    logic [4:0]  n_s;
    logic        spr_wr_s;
    logic        addr_wr_s;
    logic        clr_s;
    logic        short_s;
    logic        stall_s;
    logic        consume_s;
    logic        append_s;
    logic [5:0]  shamt_s;
    logic [31:0] peek_s;
    logic [31:0] base_buf_s;
    logic [5:0]  base_cnt_s;
    logic [6:0]  sum_s;

    // Get-bit request decode: clamp N, stall/consume decision, peeked bits
    always_comb begin
        n_s       = (num_bits_to_read_i > 5'd16) ? 5'd16 : num_bits_to_read_i;
        spr_wr_s  = spr_cs & spr_write;
        short_s   = ({1'b0, n_s} > cnt_q);
        stall_s   = get_bit_op_i & short_s & ~marker_q & ~spr_wr_s;
        consume_s = get_bit_op_i & ~spr_wr_s & (~short_s | marker_q);
        shamt_s   = 6'd32 - {1'b0, n_s};
        if (n_s == 5'd0) begin
            peek_s = 32'd0;
        end else begin
            peek_s = bitbuf_q >> shamt_s;
        end
    end

    assign stall_cpu_o = stall_s;
    assign bits_o      = (get_bit_op_i & ~stall_s) ? peek_s : 32'd0;
    assign load_byte_o = (state_q != ST_IDLE);
    assign vlx_addr_o  = addr_q;

    // SPR read mux
    always_comb begin
        case (spr_addr)
            2'd0:    spr_dat_o = {22'd0, marker_q, en_q, 1'b0, 1'b0, cnt_q};
            2'd1:    spr_dat_o = bitbuf_q;
            2'd2:    spr_dat_o = addr_q;
            2'd3:    spr_dat_o = 32'd0;
            default: spr_dat_o = 32'd0;
        endcase
    end

    // Next-state: SPR effects, consume, fetch FSM and byte append
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        en_d      = en_q;
        marker_d  = marker_q;
        append_s  = 1'b0;
        addr_wr_s = spr_wr_s & (spr_addr == 2'd2);
        clr_s     = spr_wr_s & (((spr_addr == 2'd0) & spr_dat_i[0]) | (spr_addr == 2'd2));

        // Marker padding: a short consume simply empties the buffer.
        if (consume_s) begin
            base_buf_s = bitbuf_q << n_s;
            base_cnt_s = short_s ? 6'd0 : (cnt_q - {1'b0, n_s});
        end else begin
            base_buf_s = bitbuf_q;
            base_cnt_s = cnt_q;
        end

        if (clr_s) begin
            base_buf_s = 32'd0;
            base_cnt_s = 6'd0;
            marker_d   = 1'b0;
        end else begin
            marker_d   = marker_q;
        end

        if (addr_wr_s) begin
            addr_d = spr_dat_i;
            en_d   = 1'b1;
        end else if (spr_wr_s & (spr_addr == 2'd3) & ~spr_dat_i[0]) begin
            en_d   = 1'b0;
        end else begin
            en_d   = en_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_q & ~marker_q & (cnt_q <= 6'd24)) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An address rewrite orphans the outstanding request.
                if (addr_wr_s) begin
                    state_d = ack_i ? ST_IDLE : ST_DRAIN;
                end else if (ack_i) begin
                    addr_d   = addr_q + 32'd1;
                    append_s = 1'b1;
                    state_d  = (dat_i == 8'hFF) ? ST_FF_REQ : ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FF_REQ: begin
                if (addr_wr_s) begin
                    state_d = ack_i ? ST_IDLE : ST_DRAIN;
                end else if (ack_i) begin
                    addr_d  = addr_q + 32'd1;
                    state_d = ST_IDLE;
                    if (dat_i != 8'h00) begin
                        marker_d = 1'b1;
                    end else begin
                        marker_d = marker_q;
                    end
                end else begin
                    state_d = ST_FF_REQ;
                end
            end
            ST_DRAIN: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sum_s = {1'b0, base_cnt_s} + 7'd8;
        if (append_s) begin
            bitbuf_d = base_buf_s | ({dat_i, 24'd0} >> base_cnt_s);
            cnt_d    = (sum_s > 7'd32) ? 6'd32 : sum_s[5:0];
        end else begin
            bitbuf_d = base_buf_s;
            cnt_d    = base_cnt_s;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            bitbuf_q <= 32'd0;
            cnt_q    <= 6'd0;
            addr_q   <= 32'd0;
            en_q     <= 1'b0;
            marker_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitbuf_q <= bitbuf_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            marker_q <= marker_d;
        end
    end

endmodule

// File: tb/tb_or1200_vlx_rd.sv
// Self-checking bench for or1200_vlx_rd: directed scenarios plus randomized
// byte streams checked against a destuffed bit-queue reference model.
module tb_or1200_vlx_rd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        get = 1'b0;
    logic [4:0]  nb = 5'd0;
    logic        spr_cs = 1'b0;
    logic        spr_write = 1'b0;
    logic [1:0]  spr_addr = 2'd0;
    logic [31:0] spr_dat_in = 32'd0;
    logic [31:0] bits_o, spr_dat_o, vlx_addr_o;
    logic        stall_cpu_o, load_byte_o;
    logic        man_ack = 1'b0;
    logic [7:0]  man_dat = 8'd0;
    logic        auto_ack = 1'b0;
    logic [7:0]  auto_dat = 8'd0;
    logic        ack_i;
    logic [7:0]  dat_i;
    int          tb_mode = 2;          // 0 always ack, 1 random ack, 2 manual
    logic [7:0]  mem [0:4095];
    logic [31:0] ack_log [$];
    bit          exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    assign ack_i = (tb_mode == 2) ? man_ack : auto_ack;
    assign dat_i = (tb_mode == 2) ? man_dat : auto_dat;

    always #5 clk = ~clk;

    or1200_vlx_rd dut (
        .clk_i(clk), .rst_i(rst), .get_bit_op_i(get), .num_bits_to_read_i(nb),
        .bits_o(bits_o), .stall_cpu_o(stall_cpu_o),
        .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr),
        .spr_dat_i(spr_dat_in), .spr_dat_o(spr_dat_o),
        .vlx_addr_o(vlx_addr_o), .load_byte_o(load_byte_o),
        .ack_i(ack_i), .dat_i(dat_i)
    );

    // Memory responder: decides the ack for the current cycle just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (load_byte_o && (tb_mode == 0 || (tb_mode == 1 && $urandom_range(0, 2) == 0))) begin
                auto_ack = 1'b1;
                auto_dat = mem[vlx_addr_o[11:0]];
                ack_log.push_back(vlx_addr_o);
            end else begin
                auto_ack = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_in = d;
        @(negedge clk);
        spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'd0; spr_dat_in = 32'd0;
    endtask

    task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        spr_addr = a;
        #1;
        d = spr_dat_o;
    endtask

    task automatic do_get(input string tag, input int n, input logic [31:0] exp, output int waits);
        @(negedge clk);
        get = 1'b1;
        nb = n[4:0];
        #1;
        waits = 0;
        while (stall_cpu_o && waits < 300) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check_eq("get_timeout", (waits < 300), 32'd1);
        check_eq(tag, bits_o, exp);
        @(negedge clk);
        get = 1'b0;
    endtask

    task automatic wait_load(input string tag);
        int w = 0;
        @(negedge clk);
        while (!load_byte_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq(tag, (w < 50), 32'd1);
    endtask

    task automatic man_ack_byte(input logic [7:0] b);
        wait_load("man_req");
        man_ack = 1'b1;
        man_dat = b;
        @(negedge clk);
        man_ack = 1'b0;
    endtask

    task automatic restart(input logic [31:0] a, input int m);
        int w = 0;
        spr_wr(2'd3, 32'd0);
        while (load_byte_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("restart_idle", (w < 50), 32'd1);
        tb_mode = m;
        ack_log.delete();
        spr_wr(2'd2, a);
    endtask

    // Build a random stuffed stream ending in a marker, and its destuffed bits
    task automatic run_random(input logic [31:0] start, input int nbytes);
        int idx = int'(start);
        int a;
        int n, k, w, extra;
        logic [7:0]  b, nxt;
        logic [31:0] val, d;
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                mem[idx] = 8'hFF; mem[idx + 1] = 8'h00; idx += 2;
            end else begin
                mem[idx] = 8'($urandom_range(0, 254)); idx++;
            end
        end
        mem[idx] = 8'hFF;
        mem[idx + 1] = 8'($urandom_range(1, 255));
        exp_q.delete();
        a = int'(start);
        forever begin
            b = mem[a]; a++;
            for (int j = 7; j >= 0; j--) exp_q.push_back(b[j]);
            if (b == 8'hFF) begin
                nxt = mem[a]; a++;
                if (nxt != 8'h00) break;
            end
        end
        restart(start, 1);
        extra = 0;
        while (exp_q.size() > 0 || extra < 3) begin
            n = $urandom_range(0, 31);
            k = (n > 16) ? 16 : n;
            val = 32'd0;
            for (int j = 0; j < k; j++) begin
                val = {val[30:0], (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0};
            end
            do_get("rand_get", n, val, w);
            if (exp_q.size() == 0) extra++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        spr_rd(2'd0, d);
        check_eq("rand_marker", {31'd0, d[9]}, 32'd1);
        check_eq("rand_cnt", {25'd0, d[6:0]}, 32'd0);
    endtask

    initial begin
        int w, lc;
        logic [31:0] d;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_bits", bits_o, 32'd0);
        check_eq("rst_stall", {31'd0, stall_cpu_o}, 32'd0);
        check_eq("rst_load", {31'd0, load_byte_o}, 32'd0);
        check_eq("rst_addr", vlx_addr_o, 32'd0);
        check_eq("rst_spr", spr_dat_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic fetch and get
        mem[12'h100] = 8'hA5; mem[12'h101] = 8'h3C;
        restart(32'h100, 0);
        do_get("t1_get4a", 4, 32'hA, w);
        check_eq("t1_stalled", {31'd0, (w > 0)}, 32'd1);
        do_get("t1_get8", 8, 32'h53, w);
        do_get("t1_get4b", 4, 32'hC, w);
        check_eq("t1_addr0", ack_log[0], 32'h100);
        check_eq("t1_addr1", ack_log[1], 32'h101);

        // 2: byte stuffing
        mem[12'h300] = 8'hFF; mem[12'h301] = 8'h00; mem[12'h302] = 8'h12;
        restart(32'h300, 0);
        do_get("t2_ff", 8, 32'hFF, w);
        do_get("t2_12", 8, 32'h12, w);
        check_eq("t2_addr0", ack_log[0], 32'h300);
        check_eq("t2_addr1", ack_log[1], 32'h301);
        check_eq("t2_addr2", ack_log[2], 32'h302);
        spr_rd(2'd0, d);
        check_eq("t2_marker", {31'd0, d[9]}, 32'd0);

        // 3: marker stops fetching and pads with zeros
        mem[12'h400] = 8'hFF; mem[12'h401] = 8'hD9;
        restart(32'h400, 0);
        do_get("t3_ff", 8, 32'hFF, w);
        repeat (3) @(negedge clk);
        spr_rd(2'd0, d);
        check_eq("t3_spr0", d, 32'h300);
        lc = 0;
        repeat (10) begin
            @(negedge clk);
            if (load_byte_o) lc++;
        end
        check_eq("t3_nofetch", lc, 32'd0);
        do_get("t3_pad", 5, 32'h0, w);
        check_eq("t3_nostall", w, 32'd0);
        spr_rd(2'd0, d);
        check_eq("t3_cnt", {25'd0, d[6:0]}, 32'd0);

        // 4: consume and append in the same cycle
        restart(32'h500, 2);
        man_ack_byte(8'hB1);
        man_ack_byte(8'hC2);
        man_ack_byte(8'hD3);
        do_get("t4_get4", 4, 32'hB, w);
        wait_load("t4_req");
        get = 1'b1; nb = 5'd16; man_ack = 1'b1; man_dat = 8'h77;
        #1;
        check_eq("t4_stall", {31'd0, stall_cpu_o}, 32'd0);
        check_eq("t4_bits", bits_o, 32'h1C2D);
        @(negedge clk);
        get = 1'b0; man_ack = 1'b0;
        spr_rd(2'd0, d);
        check_eq("t4_spr0", d, 32'h10C);
        spr_rd(2'd1, d);
        check_eq("t4_buf", d, 32'h3770_0000);

        // 5: address rewrite while a request is outstanding
        wait_load("t5_req");
        spr_wr(2'd2, 32'h200);
        #1;
        check_eq("t5_drain_load", {31'd0, load_byte_o}, 32'd1);
        check_eq("t5_drain_addr", vlx_addr_o, 32'h200);
        spr_rd(2'd0, d);
        check_eq("t5_cnt0", d, 32'h100);
        man_ack_byte(8'h99);
        spr_rd(2'd0, d);
        check_eq("t5_discard", d, 32'h100);
        check_eq("t5_addr_kept", vlx_addr_o, 32'h200);
        mem[12'h200] = 8'h5A;
        ack_log.delete();
        tb_mode = 0;
        do_get("t5_get", 8, 32'h5A, w);
        check_eq("t5_first_addr", ack_log[0], 32'h200);

        // 6: reset while a fetch is pending
        restart(32'h700, 2);
        wait_load("t6_req");
        rst = 1'b1;
        spr_addr = 2'd0;
        @(posedge clk);
        #1;
        check_eq("t6_load", {31'd0, load_byte_o}, 32'd0);
        check_eq("t6_addr", vlx_addr_o, 32'd0);
        check_eq("t6_spr", spr_dat_o, 32'd0);
        check_eq("t6_bits", bits_o, 32'd0);
        check_eq("t6_stall", {31'd0, stall_cpu_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        man_ack = 1'b1; man_dat = 8'h44;
        @(negedge clk);
        man_ack = 1'b0;
        lc = 0;
        repeat (10) begin
            @(negedge clk);
            if (load_byte_o) lc++;
        end
        check_eq("t6_nofetch", lc, 32'd0);
        spr_rd(2'd0, d);
        check_eq("t6_spr0", d, 32'd0);

        // Randomized streams against the bit-queue model
        tb_mode = 0;
        run_random(32'h800, 50);
        run_random(32'hC00, 70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_vlx_rd.md
# or1200_vlx_rd

Variable-length bit reader for the OR1200 VLX extension; the decode-side counterpart of the VLX bit-packing store path. It fetches a byte stream from memory through the VLX load handshake, strips JPEG byte stuffing (0xFF 0x00 becomes 0xFF), and keeps an MSB-aligned 32-bit bit buffer. The CPU's get-bit operation returns 1..16 bits right-aligned and stalls the CPU while the buffer holds too few bits. The block is configured and inspected through the VLX SPR window.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- get_bit_op_i  in  1  high while a get-bit instruction is in progress; held until stall_cpu_o is low.
- num_bits_to_read_i  in  5  bits requested, N; legal range 0..16, values >16 clamp to 16.
- bits_o  out  32  requested bits, right-aligned and zero-extended; valid when get_bit_op_i=1 and stall_cpu_o=0.
- stall_cpu_o  out  1  stalls the CPU pipeline.
- spr_cs, spr_write  in  1 each  SPR access strobes.
- spr_addr  in  2  SPR select.
- spr_dat_i  in  32  SPR write data.
- spr_dat_o  out  32  SPR read data; combinational from spr_addr.
- vlx_addr_o  out  32  byte address of the current fetch.
- load_byte_o  out  1  fetch request.
- ack_i  in  1  fetch acknowledge; dat_i is valid in the same cycle.
- dat_i  in  8  fetched byte.

## Operation
**State**
- buf[31:0]: valid bits occupy buf[31:32-cnt].
- cnt: 0..32.
- addr: 32-bit fetch address.
- en: fetching enabled.
- marker: a non-stuffed 0xFF xx sequence was seen.
- Fetch FSM states: IDLE, REQ, FF_REQ, DRAIN.

**SPR map**
- 0: read returns {22'b0, marker, en, 1'b0, cnt[6:0]}. A write with bit0=1 clears buf, cnt and marker and keeps addr.
- 1: read returns buf.
- 2: read returns addr. A write sets addr and en=1 and clears buf, cnt and marker.
- 3: read returns 0. A write with bit0=0 clears en.

**Fetch FSM**
- IDLE: if en & ~marker & cnt<=24, go to REQ.
- REQ: load_byte_o=1 and vlx_addr_o=addr. On ack_i:
  - addr increments by 1.
  - If dat_i!=0xFF: append the byte and go to IDLE.
  - If dat_i==0xFF: append 0xFF and go to FF_REQ.
- FF_REQ: load_byte_o=1. On ack_i, addr increments by 1 and then:
  - If dat_i==0x00: discard it and go to IDLE.
  - Otherwise: set marker, discard the byte and go to IDLE.
- Address-write abort: an SPR addr-2 write while in REQ or FF_REQ moves the FSM to DRAIN.
  - DRAIN keeps load_byte_o=1 until ack_i, discards the byte, and does not change the new addr.
  - The FSM then returns to IDLE.
- Append: the byte is placed at buf[31-c : 24-c], where c is the count after this cycle's consume. cnt becomes c+8.
- FF_REQ holds even if cnt>24 at that point. The headroom of 8 bits is guaranteed because REQ starts only at cnt<=24 and a consume only lowers cnt.

**Get-bit**
- stall_cpu_o = get_bit_op_i & (cnt<N) & ~marker.
- Consume when not stalled:
  - bits_o = buf >> (32-N); bits_o=0 when N=0.
  - buf shifts left by N and cnt decreases by N in the same edge.
- Marker padding: with marker set and cnt<N, missing low bits read as 0 and cnt becomes 0; no stall.
- Consume and append in the same cycle: shift first, then place the byte at the new c.
- SPR writes take priority over a same-cycle consume: the consume is dropped and the CPU is not stalled.

## Timing
- Reset values:
  - Outputs: bits_o=0, stall_cpu_o=0, load_byte_o=0, vlx_addr_o=0, spr_dat_o=0 (spr_addr=0).
  - Internal state: buf=0, cnt=0, en=0, marker=0, FSM=IDLE.
- Reset while load_byte_o is high drops the request on the next edge; a late ack_i is ignored.
- A request starts 1 cycle after its entry condition holds. load_byte_o stays high until the ack edge and is low the cycle after.
- Back-to-back fetches have at least 1 idle cycle between acks (REQ to IDLE to REQ).
- Get-bit latency: 0 cycles when cnt>=N. Otherwise the stall releases in the cycle after the ack that makes cnt>=N.
- Minimum first-bits latency after an addr write: 3 cycles with ack in the first REQ cycle.
- Arithmetic: cnt is 6 bits internally, saturating at 32. The SPR read of cnt is zero-extended.

## Test plan
1. Write addr=0x100; memory holds 0xA5, 0x3C. Get N=4 -> stall until the first ack, then bits_o=0xA. Get N=8 -> bits_o=0x53. Get N=4 -> bits_o=0xC. vlx_addr_o=0x100 then 0x101.
2. Stuffing: bytes 0xFF, 0x00, 0x12. Get N=8 -> 0xFF. Get N=8 -> 0x12. addr advances by 3 and marker=0.
3. Marker: bytes 0xFF, 0xD9. Get N=8 -> 0xFF. Then marker=1 and fetching stops. Get N=5 -> 0x00 with no stall and cnt=0.
4. Simultaneous events: with cnt=20, a get of N=16 and an ack of 0x77 in the same cycle -> cnt=12 and buf[31:24] holds the 4 leftover bits followed by 0x7 from the 0x77.
5. Abort: write addr=0x200 during REQ. The late ack byte is discarded. The next fetch is at 0x200 and the SPR read of cnt=0 after the write.
6. Reset mid-fetch: assert rst_i while load_byte_o=1 -> all outputs 0 the next cycle and no fetch until addr is written.
